// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings,
// FSM state constants and the default datapath/counter widths.
package mdu_pkg;

    localparam int MDU_DATA_WIDTH = 32;
    localparam int MDU_CNT_W      = $clog2(MDU_DATA_WIDTH);

    // op[1] selects divide, op[0] selects the unsigned variant
    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    typedef logic [1:0] mdu_state_t;

    localparam mdu_state_t MDU_IDLE = 2'd0;
    localparam mdu_state_t MDU_RUN  = 2'd1;
    localparam mdu_state_t MDU_FIX  = 2'd2;
    localparam mdu_state_t MDU_DONE = 2'd3;

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module mdu_div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem,
    input  logic [W-1:0] quot,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_next,
    output logic [W-1:0] quot_next
);

    logic [W:0]   shifted_s;
    logic         fits_s;
    logic [W-1:0] diff_s;

    // Trial subtraction; the difference always fits W bits when it is kept
    always_comb begin
        shifted_s = {rem, quot[W-1]};
        fits_s    = (shifted_s >= {1'b0, divisor});
        diff_s    = shifted_s[W-1:0] - divisor;
        if (fits_s) begin
            rem_next  = diff_s;
            quot_next = {quot[W-2:0], 1'b1};
        end else begin
            rem_next  = shifted_s[W-1:0];
            quot_next = {quot[W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit (MULT/MULTU/DIV/DIVU, MTHI/MTLO).
// Magnitudes are processed unsigned; signs are applied in the FIX cycle.
// Optional: define MDU_EARLY_TERM_EN to end multiplies once the remaining
// multiplier bits are all zero.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int DATA_WIDTH = MDU_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic                  mthi,
    input  logic                  mtlo,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero
);

    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    mdu_state_t     state_r;
    logic [CNT_W-1:0] cnt_r;
    logic           is_div_r;
    logic           neg_res_r;
    logic           neg_rem_r;
    logic [2*W-1:0] mcand_r;
    logic [W-1:0]   mplier_r;
    logic [2*W-1:0] prod_r;
    logic [W-1:0]   rem_r;
    logic [W-1:0]   quot_r;
    logic [W-1:0]   divisor_r;
    logic [W-1:0]   hi_r;
    logic [W-1:0]   lo_r;
    logic           busy_r;
    logic           done_r;
    logic           dbz_r;

    logic           signed_op_s;
    logic [W-1:0]   abs_a_s;
    logic [W-1:0]   abs_b_s;
    logic           b_zero_s;
    logic [2*W-1:0] prod_add_s;
    logic [2*W-1:0] prod_fix_s;
    logic [W-1:0]   quot_fix_s;
    logic [W-1:0]   rem_fix_s;
    logic [W-1:0]   rem_nxt_s;
    logic [W-1:0]   quot_nxt_s;
    logic           last_iter_s;

    mdu_div_step #(.W(W)) u_div_step (
        .rem       (rem_r),
        .quot      (quot_r),
        .divisor   (divisor_r),
        .rem_next  (rem_nxt_s),
        .quot_next (quot_nxt_s)
    );

    // Operand magnitudes, multiply accumulate and final sign correction
    always_comb begin
        signed_op_s = ~op[0];
        abs_a_s     = (signed_op_s && A[W-1]) ? -A : A;
        abs_b_s     = (signed_op_s && B[W-1]) ? -B : B;
        b_zero_s    = (B == {W{1'b0}});
        prod_add_s  = mplier_r[0] ? (prod_r + mcand_r) : prod_r;
        prod_fix_s  = neg_res_r ? -prod_r : prod_r;
        quot_fix_s  = neg_res_r ? -quot_r : quot_r;
        rem_fix_s   = neg_rem_r ? -rem_r : rem_r;
`ifdef MDU_EARLY_TERM_EN
        if (is_div_r) begin
            last_iter_s = (cnt_r == CNT_ZERO);
        end else begin
            last_iter_s = (cnt_r == CNT_ZERO) ||
                          (mplier_r[W-1:1] == {(W-1){1'b0}});
        end
`else
        last_iter_s = (cnt_r == CNT_ZERO);
`endif
    end

    // Control FSM, iteration counter and the busy/done/div_by_zero flags
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r   <= MDU_IDLE;
            cnt_r     <= CNT_ZERO;
            is_div_r  <= 1'b0;
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            dbz_r     <= 1'b0;
        end else begin
            case (state_r)
                MDU_IDLE: begin
                    done_r <= 1'b0;
                    dbz_r  <= 1'b0;
                    if (start) begin
                        is_div_r  <= op[1];
                        neg_res_r <= signed_op_s & (A[W-1] ^ B[W-1]);
                        neg_rem_r <= signed_op_s & A[W-1];
                        if (op[1] && b_zero_s) begin
                            state_r <= MDU_DONE;
                            done_r  <= 1'b1;
                            dbz_r   <= 1'b1;
                        end else begin
                            state_r <= MDU_RUN;
                            cnt_r   <= CNT_INIT;
                            busy_r  <= 1'b1;
                        end
                    end
                end
                MDU_RUN: begin
                    cnt_r <= cnt_r - CNT_ONE;
                    if (last_iter_s) begin
                        state_r <= MDU_FIX;
                    end
                end
                MDU_FIX: begin
                    state_r <= MDU_DONE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                end
                MDU_DONE: begin
                    state_r <= MDU_IDLE;
                    done_r  <= 1'b0;
                    dbz_r   <= 1'b0;
                end
                default: begin
                    state_r <= MDU_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    dbz_r   <= 1'b0;
                end
            endcase
        end
    end

    // Iteration datapath and the architectural HI/LO registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mcand_r   <= {(2*W){1'b0}};
            mplier_r  <= {W{1'b0}};
            prod_r    <= {(2*W){1'b0}};
            rem_r     <= {W{1'b0}};
            quot_r    <= {W{1'b0}};
            divisor_r <= {W{1'b0}};
            hi_r      <= {W{1'b0}};
            lo_r      <= {W{1'b0}};
        end else begin
            case (state_r)
                MDU_IDLE: begin
                    if (start) begin
                        mcand_r   <= {{W{1'b0}}, abs_a_s};
                        mplier_r  <= abs_b_s;
                        prod_r    <= {(2*W){1'b0}};
                        rem_r     <= {W{1'b0}};
                        quot_r    <= abs_a_s;
                        divisor_r <= abs_b_s;
                    end else begin
                        if (mthi) begin
                            hi_r <= A;
                        end
                        if (mtlo) begin
                            lo_r <= A;
                        end
                    end
                end
                MDU_RUN: begin
                    if (is_div_r) begin
                        rem_r  <= rem_nxt_s;
                        quot_r <= quot_nxt_s;
                    end else begin
                        prod_r   <= prod_add_s;
                        mcand_r  <= {mcand_r[2*W-2:0], 1'b0};
                        mplier_r <= {1'b0, mplier_r[W-1:1]};
                    end
                end
                MDU_FIX: begin
                    if (is_div_r) begin
                        hi_r <= rem_fix_s;
                        lo_r <= quot_fix_s;
                    end else begin
                        hi_r <= prod_fix_s[2*W-1:W];
                        lo_r <= prod_fix_s[W-1:0];
                    end
                end
                default: begin
                    hi_r <= hi_r;
                end
            endcase
        end
    end

    assign hi          = hi_r;
    assign lo          = lo_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus random ops
// compared against an arithmetic reference of HI/LO.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        nrst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        mthi;
    logic        mtlo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_hi  = 32'd0;
    logic [31:0] m_lo  = 32'd0;

    mult_div_unit #(.DATA_WIDTH(32)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .start       (start),
        .op          (op),
        .A           (A),
        .B           (B),
        .mthi        (mthi),
        .mtlo        (mtlo),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {HI, LO} from plain arithmetic: truncating division, remainder takes dividend sign
    function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa;
        longint sb;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        res = 64'd0;
        case (o)
            2'b00: res = sa * sb;
            2'b01: res = {32'd0, a} * {32'd0, b};
            2'b10: if (b != 32'd0) res = {32'(sa % sb), 32'(sa / sb)};
            2'b11: if (b != 32'd0) res = {a % b, a / b};
            default: res = 64'd0;
        endcase
        return res;
    endfunction

    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int inject_at, input logic mt_with);
        logic [63:0] r;
        logic dz;
        logic hold_ok;
        int n;
        int bcnt;
        dz = o[1] && (b == 32'd0);
        r  = ref_res(o, a, b);
        op = o; A = a; B = b; start = 1'b1; mthi = mt_with; mtlo = mt_with;
        tick;
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        n = 1; bcnt = 0; hold_ok = 1'b1;
        while (!done && n < 60) begin
            if (busy) bcnt++;
            if (hi !== m_hi || lo !== m_lo) hold_ok = 1'b0;
            if (n == inject_at) begin
                start = 1'b1; op = 2'b11; A = 32'd100; B = 32'd7; mthi = 1'b1; mtlo = 1'b1;
            end
            tick;
            start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
            n++;
        end
        check("done_seen", done, 1'b1);
`ifdef MDU_EARLY_TERM_EN
        if (o[1] || dz) begin
            check("latency", n, dz ? 1 : 34);
            check("busy_cycles", bcnt, dz ? 0 : 33);
        end else begin
            check("latency_range", (n >= 3 && n <= 34), 1'b1);
            check("busy_cycles", bcnt, n - 1);
        end
`else
        check("latency", n, dz ? 1 : 34);
        check("busy_cycles", bcnt, dz ? 0 : 33);
`endif
        check("hold_during_run", hold_ok, 1'b1);
        check("div_by_zero", div_by_zero, dz);
        check("busy_at_done", busy, 1'b0);
        if (!dz) begin
            m_hi = r[63:32];
            m_lo = r[31:0];
        end
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
        tick;
        check("done_one_cycle", done, 1'b0);
        check("dbz_one_cycle", div_by_zero, 1'b0);
    endtask

    task automatic do_mt(input logic h, input logic l, input logic [31:0] a);
        mthi = h; mtlo = l; A = a;
        tick;
        mthi = 1'b0; mtlo = 1'b0;
        if (h) m_hi = a;
        if (l) m_lo = a;
        check("mt_hi", hi, m_hi);
        check("mt_lo", lo, m_lo);
        check("mt_no_done", done, 1'b0);
    endtask

    initial begin
        logic no_done;
        logic [1:0] ro;
        logic [31:0] ra;
        logic [31:0] rb;
        nrst = 1'b0; start = 1'b0; op = 2'b00; A = 32'd0; B = 32'd0;
        mthi = 1'b0; mtlo = 1'b0;
        #12;
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_dbz", div_by_zero, 1'b0);
        nrst = 1'b1;
        tick;

        do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0);
        check("multu_max_hi_const", hi, 32'hFFFFFFFE);
        check("multu_max_lo_const", lo, 32'h00000001);
        do_op(2'b00, 32'hFFFFFFFD, 32'd7, 0, 1'b0);
        check("mult_neg_lo_const", lo, 32'hFFFFFFEB);
        do_op(2'b10, 32'hFFFFFFF9, 32'd2, 0, 1'b0);
        check("div_neg_lo_const", lo, 32'hFFFFFFFD);
        check("div_neg_hi_const", hi, 32'hFFFFFFFF);
        do_op(2'b11, 32'd7, 32'd2, 0, 1'b0);
        do_mt(1'b1, 1'b0, 32'h1234);
        do_op(2'b10, 32'd5, 32'd0, 0, 1'b0);
        check("dbz_hi_kept", hi, 32'h1234);
        do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 0, 1'b0);
        check("ovf_lo_const", lo, 32'h80000000);
        check("ovf_hi_const", hi, 32'd0);
        do_mt(1'b0, 1'b1, 32'h55);
        do_op(2'b01, 32'd3, 32'd5, 10, 1'b0);
        check("ignored_start_lo", lo, 32'd15);
        do_op(2'b11, 32'd7, 32'd2, 0, 1'b1);
        do_mt(1'b1, 1'b1, 32'hCAFE_F00D);

        for (int i = 0; i < 12; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 :
                 ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 15)) : $urandom;
            if (ra[0] && ro[1]) ra = 32'($urandom_range(0, 1000));
            do_op(ro, ra, rb, 0, 1'b0);
            if ((i % 4) == 3) do_mt(ra[1], ra[2], $urandom);
        end

        op = 2'b01; A = 32'd123; B = 32'd456; start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 19; i++) tick;
        nrst = 1'b0;
        #1;
        m_hi = 32'd0; m_lo = 32'd0;
        check("abort_busy", busy, 1'b0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        check("abort_done", done, 1'b0);
        tick;
        tick;
        nrst = 1'b1;
        no_done = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (done || busy) no_done = 1'b0;
        end
        check("abort_no_done", no_done, 1'b1);
        check("abort_hi_after", hi, m_hi);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
